// File: rtl/recip_scheduler.sv
// Reciprocal scheduler: feeds diagonal coefficients one at a time to the shared
// reciprocal unit and collects the S1.30 results into an indexed table.
module recip_scheduler #(
  parameter int NUM_ENTRY = 16,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 31
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_coef_valid,
  input  logic signed [7:0]   i_coef,
  output logic                o_coef_ready,
  output logic                o_rc_reset,
  output logic                o_rc_valid,
  output logic [7:0]          o_rc_divisor,
  input  logic                i_rc_valid,
  input  logic [31:0]         i_rc_quotient,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [31:0]         o_rd_data,
  output logic                o_done,
  output logic                o_err_zero,
  output logic                o_err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRY - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_START,
    ACCEPT,
    CLR,
    RUN,
    STORE,
    DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [7:0]         div_q;
  logic               err_zero_q;
  logic               err_tmo_q;
  logic [31:0]        rtab [NUM_ENTRY];

  // A reply on the last allowed RUN cycle takes priority over the timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= WAIT_START;
      cnt        <= '0;
      tmo_cnt    <= '0;
      div_q      <= '0;
      err_zero_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) rtab[i] <= '0;
    end else begin
      case (state)
        WAIT_START, DONE: begin
          if (i_start) begin
            state      <= ACCEPT;
            cnt        <= '0;
            tmo_cnt    <= '0;
            err_zero_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            for (int i = 0; i < NUM_ENTRY; i++) rtab[i] <= '0;
          end
        end
        ACCEPT: begin
          if (i_coef_valid) begin
            div_q <= i_coef;
            if (i_coef == '0) begin
              rtab[cnt]  <= '0;
              err_zero_q <= 1'b1;
              state      <= STORE;
            end else begin
              state <= CLR;
            end
          end
        end
        CLR: state <= RUN;
        RUN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (i_rc_valid) begin
            rtab[cnt] <= i_rc_quotient;
            state     <= STORE;
          end else if (tmo_cnt == TMO_LAST) begin
            rtab[cnt] <= '0;
            err_tmo_q <= 1'b1;
            state     <= STORE;
          end
        end
        STORE: begin
          tmo_cnt <= '0;
          if (cnt == LAST_IDX) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ACCEPT;
          end
        end
        default: state <= WAIT_START;
      endcase
    end
  end

  // Moore outputs decoded from the state register; reset forces WAIT_START,
  // so the unit reset rises immediately with i_reset_n.
  assign o_coef_ready  = (state == ACCEPT);
  assign o_rc_reset    = (state != RUN);
  assign o_rc_valid    = (state == RUN);
  assign o_done        = (state == DONE);
  assign o_rc_divisor  = div_q;
  assign o_err_zero    = err_zero_q;
  assign o_err_timeout = err_tmo_q;

  generate
    if (NUM_ENTRY == (1 << ADDR_W)) begin : g_rd_full
      assign o_rd_data = rtab[i_rd_addr];
    end else begin : g_rd_guard
      assign o_rd_data = (int'(i_rd_addr) < NUM_ENTRY) ? rtab[i_rd_addr] : '0;
    end
  endgenerate

endmodule

// File: doc/recip_scheduler.md
Name: recip_scheduler

Overview:
- Sequences the shared reciprocal unit (S1.30 output, signed 8-bit divisor) across the NUM_ENTRY matrix diagonal coefficients of the Gauss-Seidel machine.
- Accepts coefficients over a valid/ready stream and launches one reciprocal per coefficient. Between operations it issues the per-operation reset pulse that the unit requires.
- Stores the 32-bit reciprocals in an indexed table that the iteration datapath reads. Zero divisors and unit hangs are trapped and flagged.

Parameters:
- NUM_ENTRY, 16, number of diagonal coefficients per matrix (2..256).
- ADDR_W, 4, table index width; must equal clog2(NUM_ENTRY).
- TIMEOUT, 31, maximum cycles to wait for unit o_valid after launch.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; clears table/flags, begins a new matrix.
- i_coef_valid  in  1  coefficient available.
- i_coef  in  8  signed diagonal coefficient.
- o_coef_ready  out  1  coefficient accepted when valid&ready.
- o_rc_reset  out  1  active-high reset to reciprocal unit.
- o_rc_valid  out  1  drives unit i_valid.
- o_rc_divisor  out  8  drives unit i_divisor.
- i_rc_valid  in  1  unit o_valid.
- i_rc_quotient  in  32  unit o_quotient, S1.30.
- i_rd_addr  in  ADDR_W  table read index.
- o_rd_data  out  32  table[i_rd_addr], combinational read.
- o_done  out  1  all NUM_ENTRY entries written; level until next i_start.
- o_err_zero  out  1  sticky: a zero coefficient was received.
- o_err_timeout  out  1  sticky: unit failed to respond within TIMEOUT.

Behaviour:
- Reset (i_reset_n low, async): state=WAIT_START. All outputs 0 except o_rc_reset=1, which holds the unit in reset while idle. Table=0, entry counter=0, timeout counter=0.
- States: WAIT_START, ACCEPT, CLR, RUN, STORE, DONE.
- WAIT_START: o_rc_reset=1. On i_start -> ACCEPT; clear table, counter, o_done, error flags.
- ACCEPT: o_coef_ready=1, o_rc_reset=1. On handshake, latch i_coef into divisor register.
  - If i_coef==0: write table[cnt]=0, set o_err_zero, -> STORE (unit is skipped).
  - Otherwise -> CLR.
- CLR: one cycle, o_rc_reset=1, o_rc_valid=0 -> RUN.
- RUN: o_rc_reset=0, o_rc_valid=1, o_rc_divisor held stable, timeout counter increments each cycle.
  - i_rc_valid=1: table[cnt]<=i_rc_quotient -> STORE.
  - Counter reaches TIMEOUT without i_rc_valid: table[cnt]<=0, set o_err_timeout -> STORE.
  - If i_rc_valid arrives on the same cycle as the limit, the quotient wins and no error is raised.
- STORE: o_rc_reset=1, o_rc_valid=0; clear timeout counter.
  - cnt==NUM_ENTRY-1 -> DONE.
  - Otherwise cnt++ -> ACCEPT.
- DONE: o_done=1, o_rc_reset=1. On i_start -> ACCEPT, performing the same clear as in WAIT_START.
- i_start in any other state is ignored; an in-flight matrix is never aborted except by reset.
- o_coef_ready is 0 in every state except ACCEPT.
- o_rc_divisor is the registered latched coefficient. It is stable from CLR through RUN.
- Latency per nonzero coefficient: handshake cycle + 1 (CLR) + unit latency + 1 (STORE). The next coefficient is accepted at the earliest in the cycle after STORE.
- Table write occurs in the RUN/ACCEPT cycle; the value is visible on o_rd_data the following cycle. An out-of-range i_rd_addr (>=NUM_ENTRY) returns 0.
- Reset mid-operation: immediately returns to WAIT_START and clears table and flags. o_rc_reset rises asynchronously with reset.

Test Plan:
- Reset, i_start, stream 4,1,-2,… (16 entries) with a behavioural unit model → table[0]=0x1000_0000, table[1]=0x4000_0000, table[2]=0xE000_0000. o_done rises one cycle after the 16th STORE; o_rc_reset pulses between every operation.
- Coefficient 0 at index 3 → o_rc_valid never asserts for that entry, table[3]=0, o_err_zero=1. Remaining entries are still computed and o_done=1.
- Stub unit that never asserts i_rc_valid → after exactly 31 RUN cycles, table[cnt]=0, o_err_timeout=1, and the scheduler advances to the next coefficient.
- i_coef_valid deasserted for 10 cycles mid-stream → state stays in ACCEPT, o_rc_valid=0, no table writes. Resumes correctly on the next valid.
- i_start pulsed during RUN → ignored, the current result is stored. i_start in DONE → o_done=0, table cleared, o_coef_ready=1 on the next cycle.
- i_reset_n asserted during RUN → all outputs return to reset values asynchronously (o_rc_reset=1, o_done=0, flags 0), table reads 0 after release.
